// File: rtl/conv_mac_sched.sv
// Convolution-window dot-product sequencer sharing one 8x8 multiplier across all taps.
// Optional CONV_MAC_MULREG_EN: registers the product before accumulation (adds a DRAIN state).

module Vedic_mul_8x8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0] ll, lh, hl, hh;

   // Four nibble partial products combined with the usual vertical/crosswise shifts
   assign ll = 8'(a[3:0]) * 8'(b[3:0]);
   assign lh = 8'(a[3:0]) * 8'(b[7:4]);
   assign hl = 8'(a[7:4]) * 8'(b[3:0]);
   assign hh = 8'(a[7:4]) * 8'(b[7:4]);
   assign p  = 16'(ll) + {4'b0, lh, 4'b0} + {4'b0, hl, 4'b0} + {hh, 8'b0};
endmodule

module conv_mac_sched #(
   parameter int unsigned TAPS  = 9,
   parameter int unsigned ACC_W = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*TAPS-1:0]     pix,
   input  logic [8*TAPS-1:0]     wgt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_acc,
   output logic                  busy
);
   localparam int unsigned K_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
`ifdef CONV_MAC_MULREG_EN
      S_DRAIN = 2'd2,
`endif
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q;
   logic [ACC_W-1:0] acc_q;
   logic [7:0]       pix_a [TAPS];
   logic [7:0]       wgt_a [TAPS];
   logic [15:0]      prod;
   logic             accept_c;
`ifdef CONV_MAC_MULREG_EN
   logic [15:0]      prod_q;
`endif

   Vedic_mul_8x8 u_mul (
      .a (pix_a[k_q]),
      .b (wgt_a[k_q]),
      .p (prod)
   );

   assign accept_c = (state_q == S_IDLE) && in_valid && in_ready;
   assign out_acc  = acc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept_c) state_d = S_RUN;
         S_RUN: begin
            if (k_q == K_LAST) begin
`ifdef CONV_MAC_MULREG_EN
               state_d = S_DRAIN;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef CONV_MAC_MULREG_EN
         S_DRAIN: state_d = S_DONE;
`endif
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Window capture, tap counter, accumulator and registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q       <= '0;
         acc_q     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef CONV_MAC_MULREG_EN
         prod_q    <= '0;
`endif
      end else begin
         in_ready  <= (state_d == S_IDLE);
         out_valid <= (state_d == S_DONE);
         busy      <= (state_d != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  for (int unsigned t = 0; t < TAPS; t++) begin
                     pix_a[t] <= pix[8*t +: 8];
                     wgt_a[t] <= wgt[8*t +: 8];
                  end
                  k_q   <= '0;
                  acc_q <= '0;
`ifdef CONV_MAC_MULREG_EN
                  prod_q <= '0;
`endif
               end
            end
            S_RUN: begin
               k_q <= k_q + K_W'(1);
`ifdef CONV_MAC_MULREG_EN
               // Cleared on accept, so the first RUN edge adds nothing
               acc_q  <= acc_q + ACC_W'(prod_q);
               prod_q <= prod;
`else
               acc_q  <= acc_q + ACC_W'(prod);
`endif
            end
`ifdef CONV_MAC_MULREG_EN
            S_DRAIN: acc_q <= acc_q + ACC_W'(prod_q);
`endif
            default: ;
         endcase
      end
   end
endmodule
